// File: rtl/plic_types_pkg.sv
// Shared register map, ID and priority types for the lite PLIC.
// Pure declarations: no latency, no flow control.
package plic_types_pkg;

  localparam int PRIO_W_DEF = 3;
  localparam int ID_W       = 5;

  localparam logic [11:0] PRIO_BASE  = 12'h000;
  localparam logic [11:0] PEND_OFF   = 12'h080;
  localparam logic [11:0] EN_OFF     = 12'h100;
  localparam logic [11:0] THRESH_OFF = 12'h200;
  localparam logic [11:0] CLAIM_OFF  = 12'h204;

  typedef logic [ID_W-1:0]       plic_id_t;
  typedef logic [PRIO_W_DEF-1:0] plic_prio_t;

  function automatic logic [9:0] word_idx(input logic [11:0] byte_addr);
    return byte_addr[11:2];
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: 2-flop synchronizer, level/rising-edge request, pending and in-flight flags.
// Pending sets 3 edges after a raw rise; a request is dropped while the source is in flight.
module plic_gateway #(
  parameter bit EDGE = 1'b0
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic irq_raw,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;
  logic pend_q,  pend_d;
  logic infl_q,  infl_d;
  logic req;

  always_comb begin
    sync1_d = irq_raw;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    req     = EDGE ? (sync2_q & ~hist_q) : sync2_q;
    pend_d  = pend_q;
    infl_d  = infl_q;
    if (req && !infl_q) begin
      pend_d = 1'b1;
    end
    // A claim in the same cycle as a request wins: the source is now in flight.
    if (claim) begin
      pend_d = 1'b0;
      infl_d = 1'b1;
    end else if (complete) begin
      infl_d = 1'b0;
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      pend_q  <= 1'b0;
      infl_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pend_q  <= pend_d;
      infl_q  <= infl_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/plic_lite.sv
// Machine-mode PLIC: gateways, priority arbitration, claim/complete register port.
// Bus ack/rdata one cycle after each request, no backpressure; interrupt output registered.
module plic_lite
  import plic_types_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter int          PRIO_W    = PRIO_W_DEF,
  parameter logic [31:0] EDGE_MASK = 32'h0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_SRC:0]   irq_src,
  input  logic               bus_ren,
  input  logic               bus_wen,
  input  logic [11:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               plic_ext_int_m,
  output logic               plic_clear_ext_int_m
);

  localparam logic [9:0] PRIO_WIDX  = word_idx(PRIO_BASE);
  localparam logic [9:0] PEND_WIDX  = word_idx(PEND_OFF);
  localparam logic [9:0] EN_WIDX    = word_idx(EN_OFF);
  localparam logic [9:0] THR_WIDX   = word_idx(THRESH_OFF);
  localparam logic [9:0] CLAIM_WIDX = word_idx(CLAIM_OFF);

  logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0] prio_d [1:NUM_SRC];
  logic [NUM_SRC:1]  en_q, en_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              ext_q, ext_d;
  logic              clr_q, clr_d;

  logic [9:0]        widx;
  logic [9:0]        prio_off;
  logic              prio_hit;
  logic              rd_go;
  plic_id_t          cmpl_id;
  logic [NUM_SRC:0]  pend_vec;
  logic [NUM_SRC:1]  elig;
  logic [NUM_SRC:1]  claim_vec;
  logic [NUM_SRC:1]  cmpl_vec;
  plic_id_t          win_id;
  logic [PRIO_W-1:0] win_prio;
  logic              claim_fire;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign widx     = word_idx(bus_addr);
  assign prio_off = widx - PRIO_WIDX;
  assign prio_hit = (prio_off < 10'd32);
  assign rd_go    = bus_ren & ~bus_wen;
  assign cmpl_id  = bus_wdata[ID_W-1:0];
  assign unused_bits = ^{irq_src[0], bus_addr[1:0], bus_wdata};

  assign pend_vec[0] = 1'b0;

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    plic_gateway #(
      .EDGE (EDGE_MASK[g])
    ) u_gw (
      .core_clk (CLK),
      .arst_n   (nRST),
      .irq_raw  (irq_src[g]),
      .claim    (claim_vec[g]),
      .complete (cmpl_vec[g]),
      .pending  (pend_vec[g])
    );
  end

  // Winner search: strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    elig     = '0;
    win_id   = '0;
    win_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      elig[i] = pend_vec[i] & en_q[i] & (prio_q[i] > thr_q);
      if (elig[i] && ((win_id == '0) || (prio_q[i] > win_prio))) begin
        win_id   = plic_id_t'(i);
        win_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    claim_fire = rd_go && (widx == CLAIM_WIDX) && (win_id != '0);
    claim_vec  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (claim_fire && (win_id == plic_id_t'(i))) begin
        claim_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d   = prio_q;
    en_d     = en_q;
    thr_d    = thr_q;
    cmpl_vec = '0;
    if (bus_wen) begin
      if (prio_hit) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (prio_off[4:0] == 5'(i)) begin
            prio_d[i] = bus_wdata[PRIO_W-1:0];
          end
        end
      end
      if (widx == EN_WIDX) begin
        en_d = bus_wdata[NUM_SRC:1];
      end
      if (widx == THR_WIDX) begin
        thr_d = bus_wdata[PRIO_W-1:0];
      end
      if (widx == CLAIM_WIDX) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (cmpl_id == plic_id_t'(i)) begin
            cmpl_vec[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (prio_hit) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (prio_off[4:0] == 5'(i)) begin
          rd_val = 32'(prio_q[i]);
        end
      end
    end else if (widx == PEND_WIDX) begin
      rd_val = 32'(pend_vec);
    end else if (widx == EN_WIDX) begin
      rd_val = 32'({en_q, 1'b0});
    end else if (widx == THR_WIDX) begin
      rd_val = 32'(thr_q);
    end else if (widx == CLAIM_WIDX) begin
      rd_val = 32'(win_id);
    end
    rdata_d = rd_go ? rd_val : '0;
    ack_d   = bus_ren | bus_wen;
    ext_d   = |elig;
    clr_d   = ext_q & ~(|elig);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        prio_q[i] <= '0;
      end
      en_q    <= '0;
      thr_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      ext_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      ext_q   <= ext_d;
      clr_q   <= clr_d;
    end
  end

  assign bus_rdata            = rdata_q;
  assign bus_ack              = ack_q;
  assign plic_ext_int_m       = ext_q;
  assign plic_clear_ext_int_m = clr_q;

endmodule

// File: tb/tb_plic_lite.sv
// Scenario bench for plic_lite: expected read data queued at issue, popped and compared on ack.
module tb_plic_lite;

  localparam logic [11:0] A_PEND  = 12'h080;
  localparam logic [11:0] A_EN    = 12'h100;
  localparam logic [11:0] A_THR   = 12'h200;
  localparam logic [11:0] A_CLAIM = 12'h204;

  logic        CLK;
  logic        nRST;
  logic [8:0]  irq_src;
  logic        bus_ren;
  logic        bus_wen;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        plic_ext_int_m;
  logic        plic_clear_ext_int_m;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  plic_lite #(.NUM_SRC(8), .PRIO_W(3), .EDGE_MASK(32'h40)) dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .irq_src              (irq_src),
    .bus_ren              (bus_ren),
    .bus_wen              (bus_wen),
    .bus_addr             (bus_addr),
    .bus_wdata            (bus_wdata),
    .bus_rdata            (bus_rdata),
    .bus_ack              (bus_ack),
    .plic_ext_int_m       (plic_ext_int_m),
    .plic_clear_ext_int_m (plic_clear_ext_int_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Missing ack returns a poison word so the caller's compare catches it.
  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge CLK);
    bus_ren  = 1'b1;
    bus_addr = a;
    @(negedge CLK);
    bus_ren  = 1'b0;
    d = (bus_ack === 1'b1) ? bus_rdata : 32'hDEAD_BEEF;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] wd, output logic ack);
    @(negedge CLK);
    bus_wen   = 1'b1;
    bus_addr  = a;
    bus_wdata = wd;
    @(negedge CLK);
    bus_wen   = 1'b0;
    ack = bus_ack;
  endtask

  task automatic test_reset;
    logic [31:0] rd, e;
    checks++;
    if ({plic_ext_int_m, plic_clear_ext_int_m, bus_ack} !== 3'b000 || bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%b rdata %h exp 000 0", plic_ext_int_m, plic_clear_ext_int_m, bus_ack, bus_rdata);
    end
    exp_q.push_back(32'h0);
    bus_read(A_EN, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL reset_enable got %h exp %h", rd, e); end
    exp_q.push_back(32'h0);
    bus_read(12'h00C, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL reset_prio3 got %h exp %h", rd, e); end
  endtask

  task automatic test_level;
    logic [31:0] rd, e;
    logic ack;
    bus_write(12'h00C, 32'd2, ack);
    bus_write(A_EN, 32'h08, ack);
    bus_write(A_THR, 32'd0, ack);
    @(negedge CLK);
    irq_src[3] = 1'b1;
    tick(3);
    checks++;
    if (plic_ext_int_m !== 1'b0) begin errors++; $display("FAIL lvl_ext_edge3 got %b exp 0", plic_ext_int_m); end
    tick(1);
    checks++;
    if (plic_ext_int_m !== 1'b1) begin errors++; $display("FAIL lvl_ext_edge4 got %b exp 1", plic_ext_int_m); end
    exp_q.push_back(32'h08);
    bus_read(A_PEND, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL lvl_pending got %h exp %h", rd, e); end
    exp_q.push_back(32'd3);
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL lvl_claim got %h exp %h", rd, e); end
    tick(1);
    checks++;
    if ({plic_ext_int_m, plic_clear_ext_int_m} !== 2'b01) begin
      errors++; $display("FAIL lvl_clear_pulse got %b%b exp 01", plic_ext_int_m, plic_clear_ext_int_m);
    end
    tick(1);
    checks++;
    if (plic_clear_ext_int_m !== 1'b0) begin errors++; $display("FAIL lvl_clear_one_cycle got %b exp 0", plic_clear_ext_int_m); end
    bus_write(A_CLAIM, 32'd3, ack);
    tick(1);
    checks++;
    if (plic_ext_int_m !== 1'b0) begin errors++; $display("FAIL lvl_repend_early got %b exp 0", plic_ext_int_m); end
    tick(1);
    checks++;
    if (plic_ext_int_m !== 1'b1) begin errors++; $display("FAIL lvl_repend got %b exp 1", plic_ext_int_m); end
    irq_src[3] = 1'b0;
    tick(3);
    exp_q.push_back(32'd3);
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL lvl_claim2 got %h exp %h", rd, e); end
    bus_write(A_CLAIM, 32'd3, ack);
    tick(3);
    exp_q.push_back(32'h0);
    bus_read(A_PEND, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL lvl_idle_pending got %h exp %h", rd, e); end
  endtask

  task automatic test_arbitration;
    logic [31:0] rd, e;
    logic ack;
    bus_write(12'h008, 32'd4, ack);
    bus_write(12'h014, 32'd4, ack);
    bus_write(A_EN, 32'h2C, ack);
    @(negedge CLK);
    irq_src[2] = 1'b1;
    irq_src[5] = 1'b1;
    tick(5);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd0);
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL arb_claim_first got %h exp %h", rd, e); end
    tick(1);
    checks++;
    if (plic_ext_int_m !== 1'b1) begin errors++; $display("FAIL arb_ext_held got %b exp 1", plic_ext_int_m); end
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL arb_claim_second got %h exp %h", rd, e); end
    tick(1);
    checks++;
    if ({plic_ext_int_m, plic_clear_ext_int_m} !== 2'b01) begin
      errors++; $display("FAIL arb_ext_fall got %b%b exp 01", plic_ext_int_m, plic_clear_ext_int_m);
    end
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL arb_claim_empty got %h exp %h", rd, e); end
    irq_src[2] = 1'b0;
    irq_src[5] = 1'b0;
    tick(3);
    bus_write(A_CLAIM, 32'd2, ack);
    bus_write(A_CLAIM, 32'd5, ack);
  endtask

  task automatic test_threshold;
    logic [31:0] rd, e;
    logic ack;
    bus_write(A_THR, 32'd4, ack);
    bus_write(12'h004, 32'd4, ack);
    bus_write(A_EN, 32'h2E, ack);
    @(negedge CLK);
    irq_src[1] = 1'b1;
    tick(5);
    checks++;
    if (plic_ext_int_m !== 1'b0) begin errors++; $display("FAIL thr_masked got %b exp 0", plic_ext_int_m); end
    exp_q.push_back(32'd0);
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL thr_claim_none got %h exp %h", rd, e); end
    bus_write(A_THR, 32'd3, ack);
    checks++;
    if (plic_ext_int_m !== 1'b0) begin errors++; $display("FAIL thr_ext_same_edge got %b exp 0", plic_ext_int_m); end
    tick(1);
    checks++;
    if (plic_ext_int_m !== 1'b1) begin errors++; $display("FAIL thr_ext_next_edge got %b exp 1", plic_ext_int_m); end
    exp_q.push_back(32'd1);
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL thr_claim got %h exp %h", rd, e); end
    irq_src[1] = 1'b0;
    tick(3);
    bus_write(A_CLAIM, 32'd1, ack);
    bus_write(A_THR, 32'd0, ack);
  endtask

  task automatic test_edge_and_complete;
    logic [31:0] rd, e;
    logic ack;
    bus_write(12'h018, 32'd3, ack);
    bus_write(A_EN, 32'h6E, ack);
    for (int p = 0; p < 4; p++) begin
      @(negedge CLK);
      irq_src[6] = 1'b1;
      tick(2);
      irq_src[6] = 1'b0;
      tick(4);
      // p=0 first pulse; p=1 while in flight; p=2 after bogus completes; p=3 after real complete
      exp_q.push_back((p == 0 || p == 3) ? 32'h40 : 32'h0);
      bus_read(A_PEND, rd);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL edge_pending_%0d got %h exp %h", p, rd, e); end
      if (p == 0) begin
        exp_q.push_back(32'd6);
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front(); checks++;
        if (rd !== e) begin errors++; $display("FAIL edge_claim got %h exp %h", rd, e); end
      end else if (p == 1) begin
        bus_write(A_CLAIM, 32'd0, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL cmpl_id0_ack got %b exp 1", ack); end
        bus_write(A_CLAIM, 32'd9, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL cmpl_id9_ack got %b exp 1", ack); end
        bus_write(A_CLAIM, 32'd5, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL cmpl_idle_ack got %b exp 1", ack); end
      end else if (p == 2) begin
        bus_write(A_CLAIM, 32'd6, ack);
      end
    end
    checks++;
    if (plic_ext_int_m !== 1'b1) begin errors++; $display("FAIL edge_ext got %b exp 1", plic_ext_int_m); end
    exp_q.push_back(32'd6);
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL edge_claim_last got %h exp %h", rd, e); end
    bus_write(A_CLAIM, 32'd6, ack);
  endtask

  task automatic test_bus;
    logic [31:0] rd, e;
    logic ack;
    exp_q.push_back(32'h0);
    bus_read(12'h300, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL unmapped_read got %h exp %h", rd, e); end
    bus_write(12'h300, 32'hFFFF_FFFF, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL unmapped_write_ack got %b exp 1", ack); end
    bus_write(12'h000, 32'd7, ack);
    exp_q.push_back(32'h0);
    bus_read(12'h000, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL prio0_read got %h exp %h", rd, e); end
    @(negedge CLK);
    bus_ren = 1'b1; bus_wen = 1'b1; bus_addr = A_THR; bus_wdata = 32'd2;
    @(negedge CLK);
    bus_ren = 1'b0; bus_wen = 1'b0;
    checks++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL rw_both got ack %b rdata %h exp 1 0", bus_ack, bus_rdata);
    end
    // Back-to-back: write, read-after-write, read, on consecutive cycles.
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd2);
    @(negedge CLK);
    bus_wen = 1'b1; bus_addr = 12'h01C; bus_wdata = 32'd5;
    @(negedge CLK);
    bus_wen = 1'b0; bus_ren = 1'b1; bus_addr = 12'h01C;
    checks++;
    if (bus_ack !== 1'b1) begin errors++; $display("FAIL b2b_write_ack got %b exp 1", bus_ack); end
    @(negedge CLK);
    bus_addr = A_THR;
    rd = (bus_ack === 1'b1) ? bus_rdata : 32'hDEAD_BEEF;
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL b2b_read_prio7 got %h exp %h", rd, e); end
    @(negedge CLK);
    bus_ren = 1'b0;
    rd = (bus_ack === 1'b1) ? bus_rdata : 32'hDEAD_BEEF;
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL b2b_read_thr got %h exp %h", rd, e); end
    tick(1);
    checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL idle_bus got ack %b rdata %h exp 0 0", bus_ack, bus_rdata);
    end
    bus_write(A_THR, 32'd0, ack);
  endtask

  task automatic test_mid_reset;
    logic [31:0] rd, e;
    @(negedge CLK);
    irq_src[2] = 1'b1;
    irq_src[5] = 1'b1;
    tick(5);
    exp_q.push_back(32'h24);
    bus_read(A_PEND, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL rst_pre_pending got %h exp %h", rd, e); end
    checks++;
    if (plic_ext_int_m !== 1'b1) begin errors++; $display("FAIL rst_pre_ext got %b exp 1", plic_ext_int_m); end
    @(negedge CLK);
    bus_ren = 1'b1; bus_addr = A_PEND;
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (plic_ext_int_m !== 1'b0) begin errors++; $display("FAIL rst_async_ext got %b exp 0", plic_ext_int_m); end
    irq_src = '0;
    @(negedge CLK);
    checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_dropped_ack got ack %b rdata %h exp 0 0", bus_ack, bus_rdata);
    end
    bus_ren = 1'b0;
    tick(2);
    nRST = 1'b1;
    tick(1);
    checks++;
    if ({plic_ext_int_m, plic_clear_ext_int_m, bus_ack} !== 3'b000) begin
      errors++; $display("FAIL rst_post_outputs got %b%b%b exp 000", plic_ext_int_m, plic_clear_ext_int_m, bus_ack);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_read(A_PEND, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL rst_post_pending got %h exp %h", rd, e); end
    bus_read(A_EN, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL rst_post_enable got %h exp %h", rd, e); end
    bus_read(12'h008, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL rst_post_prio2 got %h exp %h", rd, e); end
    bus_read(A_THR, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL rst_post_thresh got %h exp %h", rd, e); end
    bus_read(A_CLAIM, rd);
    e = exp_q.pop_front(); checks++;
    if (rd !== e) begin errors++; $display("FAIL rst_post_claim got %h exp %h", rd, e); end
  endtask

  initial begin
    nRST      = 1'b0;
    irq_src   = '0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    tick(3);
    nRST = 1'b1;
    tick(1);
    test_reset();
    test_level();
    test_arbitration();
    test_threshold();
    test_edge_and_complete();
    test_bus();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
